f1_start_ctrl: RTL
==================

Name: f1_start_ctrl

Overview:
- Race-start sequencer that drives the `en` input of the 8-light F1 start-light FSM.
- On `trigger`, it issues one `en` pulse per tick to light all 8 lamps, then holds for a pseudo-random number of ticks, then issues the extinguish pulse.
- After extinguish it measures the player's reaction time in ticks. A false start aborts the run and returns the light FSM to its all-off state.
- Sits between the prescaler/button inputs and the light FSM; shares `clk`/`rst` with it.

Parameters:
- TICK_DIV, 24: clock cycles per tick, must be ≥ 2.
- LFSR_SEED, 7'h01: LFSR reset value, must be nonzero.
- MIN_DELAY, 0: ticks added to the random hold delay.
- REACT_W, 16: reaction counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- trigger  in  1  start request, level-sampled, acted on only in IDLE
- react  in  1  player button
- fsm_en  out  1  single-cycle enable pulse to the light FSM
- lights_out  out  1  one-cycle pulse, coincident with the extinguish fsm_en
- busy  out  1  high in every state except IDLE
- react_time  out  REACT_W  last measured reaction, in ticks
- react_valid  out  1  one-cycle pulse when react_time updates
- false_start  out  1  one-cycle pulse on abort

Behaviour:
- Reset: state=IDLE, all outputs 0, react_time=0, lfsr=LFSR_SEED, all counters 0. Reset mid-run gives the same result; the light FSM resets on the same rst.
- react_q: `react` registered once. All FSM decisions use react_q (1-cycle input latency).
- LFSR: 7-bit Fibonacci, next={lfsr[5:0], lfsr[6]^lfsr[5]}. Advances every clock in all states.
- Prescaler: loaded 0 on the trigger-accept cycle, then increments each cycle. tick=1 when prescaler==TICK_DIV-1, and it wraps to 0 on that cycle. The prescaler holds in IDLE and ABORT.
- fsm_en and lights_out: combinational decode of registered state/counters/react_q only.
- States:
  - IDLE: trigger=1 → go to LIGHTING; light_cnt=0; delay=lfsr+MIN_DELAY, latched this cycle. react_q is ignored.
  - LIGHTING: on each tick, fsm_en=1 and light_cnt++. The tick that makes light_cnt=8 → go to HOLD with delay_cnt=delay. Result: first pulse TICK_DIV cycles after trigger, 8 pulses spaced TICK_DIV.
  - HOLD: on each tick, delay_cnt--. On the tick where delay_cnt==1: fsm_en=1, lights_out=1 → go to TIMING with rcnt=0.
  - TIMING: on each tick, rcnt++, saturating at 2^REACT_W-1. react_q=1 → react_time<=rcnt (value before any same-cycle increment), react_valid pulses on the next cycle → go to IDLE.
  - ABORT: fsm_en=1 every clock (back-to-back) until the remaining pulses have been issued → go to IDLE. Remaining pulses = (light_cnt==0) ? 0 : 9-light_cnt. The light FSM ends in S0 with all lamps off.
- False start: react_q=1 in LIGHTING or HOLD → false_start pulses that cycle → go to ABORT.
  - react_q has priority over a same-cycle tick, so no fsm_en is issued from LIGHTING/HOLD on that cycle.
  - react_q in HOLD on the would-be extinguish cycle counts as a false start (light_cnt=8 → 1 abort pulse, no lights_out).
- trigger outside IDLE: ignored. Held trigger: re-arms only after returning to IDLE.
- react_time holds its value until the next valid reaction or reset. It is not updated on a false start.

Test Plan:
- TICK_DIV=4, MIN_DELAY=0; trigger on the first cycle after rst release (lfsr=7'h01, delay=1) → fsm_en at t+4,8,…,32 (8 pulses); fsm_en+lights_out at t+36; busy=1 from t+1.
- Same run; react asserted 40 cycles (10 ticks) after lights_out → react_valid one cycle, react_time=10, busy=0 afterwards.
- react_q rises after the 3rd lighting pulse → false_start pulse, exactly 6 consecutive-cycle fsm_en pulses, no lights_out, light FSM data_out=0, then IDLE.
- trigger held high during the whole run, and react pulsed in IDLE → no restart until IDLE; no react_valid or false_start from the IDLE press.
- rst asserted mid-HOLD → next cycle all outputs 0, busy=0; a new trigger reproduces scenario 1 timing.
- REACT_W=4, no react for 20 ticks after lights_out, then react → react_time=15 (saturated).

Source files
------------

// File: rtl/f1_start_ctrl.sv
// F1 race-start sequencer: lights 8 lamps, random hold, extinguish,
// then times the player's reaction; a false start aborts to all-off.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   trigger       start request (acted on only in IDLE)
//   react         player button (registered once before use)
//   fsm_en        single-cycle enable pulse to the light FSM
//   lights_out    pulse coincident with the extinguish fsm_en
//   busy          high in every state except IDLE
//   react_time    last measured reaction in ticks
//   react_valid   pulse when react_time updates
//   false_start   pulse on abort
module f1_start_ctrl #(
  parameter int          TICK_DIV  = 24,
  parameter logic [6:0]  LFSR_SEED = 7'h01,
  parameter int          MIN_DELAY = 0,
  parameter int          REACT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trigger,
  input  logic               react,
  output logic               fsm_en,
  output logic               lights_out,
  output logic               busy,
  output logic [REACT_W-1:0] react_time,
  output logic               react_valid,
  output logic               false_start
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(127 + MIN_DELAY + 1);

  typedef enum logic [2:0] {
    IDLE, LIGHTING, HOLD, TIMING, ABORT
  } state_t;

  state_t             state, state_n;
  logic [6:0]         lfsr;
  logic [PW-1:0]      presc, presc_n;
  logic [3:0]         light_cnt, light_cnt_n;
  logic [3:0]         abort_cnt, abort_cnt_n;
  logic [DW-1:0]      delay, delay_n;
  logic [DW-1:0]      delay_cnt, delay_cnt_n;
  logic [REACT_W-1:0] rcnt, rcnt_n;
  logic [REACT_W-1:0] react_time_n;
  logic               react_q;
  logic               valid_n;
  logic               tick;
  logic [3:0]         remain;

  assign tick = (presc == PW'(TICK_DIV - 1));
  assign busy = (state != IDLE);

  // Pulses still needed to walk the light FSM
  // round to S0: none if nothing lit yet.
  assign remain = (light_cnt == 4'd0) ? 4'd0
                : 4'd9 - light_cnt;

  always_comb begin
    state_n      = state;
    presc_n      = presc;
    light_cnt_n  = light_cnt;
    abort_cnt_n  = abort_cnt;
    delay_n      = delay;
    delay_cnt_n  = delay_cnt;
    rcnt_n       = rcnt;
    react_time_n = react_time;
    valid_n      = 1'b0;
    fsm_en       = 1'b0;
    lights_out   = 1'b0;
    false_start  = 1'b0;

    if (state == LIGHTING || state == HOLD ||
        state == TIMING) begin
      presc_n = tick ? '0 : presc + PW'(1);
    end

    unique case (state)
      IDLE: begin
        if (trigger) begin
          state_n     = LIGHTING;
          presc_n     = '0;
          light_cnt_n = 4'd0;
          delay_n     = DW'(lfsr) + DW'(MIN_DELAY);
        end
      end
      LIGHTING: begin
        if (react_q) begin
          false_start = 1'b1;
          abort_cnt_n = remain;
          state_n     = ABORT;
        end else if (tick) begin
          fsm_en      = 1'b1;
          light_cnt_n = light_cnt + 4'd1;
          if (light_cnt == 4'd7) begin
            state_n     = HOLD;
            delay_cnt_n = delay;
          end
        end
      end
      HOLD: begin
        if (react_q) begin
          false_start = 1'b1;
          abort_cnt_n = remain;
          state_n     = ABORT;
        end else if (tick) begin
          delay_cnt_n = delay_cnt - DW'(1);
          if (delay_cnt == DW'(1)) begin
            fsm_en     = 1'b1;
            lights_out = 1'b1;
            rcnt_n     = '0;
            state_n    = TIMING;
          end
        end
      end
      TIMING: begin
        if (react_q) begin
          react_time_n = rcnt;
          valid_n      = 1'b1;
          state_n      = IDLE;
        end else if (tick && rcnt != '1) begin
          rcnt_n = rcnt + REACT_W'(1);
        end
      end
      ABORT: begin
        if (abort_cnt == 4'd0) begin
          state_n = IDLE;
        end else begin
          fsm_en      = 1'b1;
          abort_cnt_n = abort_cnt - 4'd1;
          if (abort_cnt == 4'd1) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      presc       <= '0;
      light_cnt   <= '0;
      abort_cnt   <= '0;
      delay       <= '0;
      delay_cnt   <= '0;
      rcnt        <= '0;
      react_time  <= '0;
      react_valid <= 1'b0;
      react_q     <= 1'b0;
    end else begin
      state       <= state_n;
      lfsr        <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      presc       <= presc_n;
      light_cnt   <= light_cnt_n;
      abort_cnt   <= abort_cnt_n;
      delay       <= delay_n;
      delay_cnt   <= delay_cnt_n;
      rcnt        <= rcnt_n;
      react_time  <= react_time_n;
      react_valid <= valid_n;
      react_q     <= react;
    end
  end

endmodule
